// File: rtl/mul_result_combiner.sv
// Two-stage combiner assembling the low 32 bits of a 32x32 product from three 16x16 partials.
// Optional registered zero flag when MUL_COMBINE_ZERO_FLAG_EN is defined.
module mul_result_combiner (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] M_mul_cell_p1,
  input  logic [31:0] M_mul_cell_p2,
  input  logic [31:0] M_mul_cell_p3,
  input  logic        mul_in_valid,
  input  logic [4:0]  mul_in_tag,
  output logic        mul_in_ready,
  input  logic        mul_flush,
  input  logic        mul_out_ready,
  output logic        mul_out_valid,
  output logic [31:0] mul_out_result,
  output logic [4:0]  mul_out_tag,
  output logic        mul_out_zero
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned HALF_W = 16;
  localparam int unsigned TAG_W  = 5;

  logic              s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0] s1_p1_q;
  logic [HALF_W-1:0] s1_cross_q, s1_cross_d;
  logic [TAG_W-1:0]  s1_tag_q;

  logic              s2_valid_q, s2_valid_d;
  logic [DATA_W-1:0] s2_result_q, s2_result_d;
  logic [TAG_W-1:0]  s2_tag_q;

  logic s2_free, xfer, accept;

  // Upper halves of the cross partials only affect bits above 31.
  logic unused_upper;
  assign unused_upper = ^{M_mul_cell_p2[31:16], M_mul_cell_p3[31:16]};

  // Handshake and next-state logic.
  always_comb begin
    s2_free      = !s2_valid_q || mul_out_ready;
    xfer         = s1_valid_q && s2_free;
    mul_in_ready = !s1_valid_q || s2_free;
    accept       = mul_in_valid && mul_in_ready;
    s1_cross_d   = HALF_W'(M_mul_cell_p2[HALF_W-1:0] + M_mul_cell_p3[HALF_W-1:0]);
    s2_result_d  = s1_p1_q + {s1_cross_q, HALF_W'(0)};

    s1_valid_d = s1_valid_q;
    if (mul_flush)   s1_valid_d = 1'b0;
    else if (accept) s1_valid_d = 1'b1;
    else if (xfer)   s1_valid_d = 1'b0;

    s2_valid_d = s2_valid_q;
    if (mul_flush)          s2_valid_d = 1'b0;
    else if (xfer)          s2_valid_d = 1'b1;
    else if (mul_out_ready) s2_valid_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
    end
  end

  // Stage 1 data loads only on an accepted input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_p1_q    <= '0;
      s1_cross_q <= '0;
      s1_tag_q   <= '0;
    end else if (accept) begin
      s1_p1_q    <= M_mul_cell_p1;
      s1_cross_q <= s1_cross_d;
      s1_tag_q   <= mul_in_tag;
    end
  end

  // Stage 2 data loads only on a transfer, so stalled outputs hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_result_q <= '0;
      s2_tag_q    <= '0;
    end else if (xfer) begin
      s2_result_q <= s2_result_d;
      s2_tag_q    <= s1_tag_q;
    end
  end

`ifdef MUL_COMBINE_ZERO_FLAG_EN
  logic s2_zero_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     s2_zero_q <= 1'b0;
    else if (xfer) s2_zero_q <= (s2_result_d == '0);
  end

  assign mul_out_zero = s2_zero_q;
`else
  assign mul_out_zero = 1'b0;
`endif

  assign mul_out_valid  = s2_valid_q;
  assign mul_out_result = s2_result_q;
  assign mul_out_tag    = s2_tag_q;

endmodule

// File: tb/tb_mul_result_combiner.sv
// Directed self-checking bench for mul_result_combiner; inputs driven after posedge, outputs sampled at negedge.
module tb_mul_result_combiner;

  logic        clk;
  logic        reset;
  logic [31:0] p1, p2, p3;
  logic        in_valid;
  logic [4:0]  in_tag;
  logic        in_ready;
  logic        flush;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] out_result;
  logic [4:0]  out_tag;
  logic        out_zero;

  int n_checks;
  int n_errors;

`ifdef MUL_COMBINE_ZERO_FLAG_EN
  localparam logic EXP_ZERO = 1'b1;
`else
  localparam logic EXP_ZERO = 1'b0;
`endif

  mul_result_combiner dut (
    .clk            (clk),
    .reset          (reset),
    .M_mul_cell_p1  (p1),
    .M_mul_cell_p2  (p2),
    .M_mul_cell_p3  (p3),
    .mul_in_valid   (in_valid),
    .mul_in_tag     (in_tag),
    .mul_in_ready   (in_ready),
    .mul_flush      (flush),
    .mul_out_ready  (out_ready),
    .mul_out_valid  (out_valid),
    .mul_out_result (out_result),
    .mul_out_tag    (out_tag),
    .mul_out_zero   (out_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [4:0] t,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    in_valid = v;
    in_tag   = t;
    p1       = a;
    p2       = b;
    p3       = c;
  endtask

  task automatic chk_out(input string tag, input logic [4:0] t, input logic [31:0] r);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_tag"}, 32'(out_tag), 32'(t));
    chk({tag, "_result"}, out_result, r);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    reset     = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
    #2;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_result", out_result, 32'h0);
    chk("rst_tag", 32'(out_tag), 32'd0);
    chk("rst_zero", 32'(out_zero), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    tick(); tick();
    reset = 1'b0;

    // Basic product and latency.
    drive(1'b1, 5'd3, 32'h0000_0008, 32'h0000_000A, 32'h0000_000C);
    sample(); chk("basic_in_ready", 32'(in_ready), 32'd1);
    tick(); drive(1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
    sample(); chk("basic_lat_not_yet", 32'(out_valid), 32'd0);
    tick();
    sample(); chk_out("basic", 5'd3, 32'h0016_0008);
    chk("basic_zero", 32'(out_zero), 32'd0);
    tick();
    sample(); chk("basic_drained", 32'(out_valid), 32'd0);

    // Wrap-around: -1 * -1.
    drive(1'b1, 5'd9, 32'hFFFE_0001, 32'hFFFE_0001, 32'hFFFE_0001);
    tick(); drive(1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
    tick();
    sample(); chk_out("wrap", 5'd9, 32'h0000_0001);
    tick();

    // Back-pressure with four back-to-back ops.
    out_ready = 1'b0;
    drive(1'b1, 5'd1, 32'h0000_0100, 32'h0000_0001, 32'h0000_0001);
    sample(); chk("bp_rdy1", 32'(in_ready), 32'd1);
    tick(); drive(1'b1, 5'd2, 32'h0000_0200, 32'h0000_0002, 32'h0000_0001);
    sample(); chk("bp_rdy2", 32'(in_ready), 32'd1);
    tick(); drive(1'b1, 5'd3, 32'h0000_0300, 32'h0000_0003, 32'h0000_0001);
    sample(); chk("bp_full_rdy", 32'(in_ready), 32'd0);
    chk_out("bp_hold0", 5'd1, 32'h0002_0100);
    tick();
    sample(); chk("bp_full_rdy2", 32'(in_ready), 32'd0);
    chk_out("bp_hold1", 5'd1, 32'h0002_0100);
    tick();
    out_ready = 1'b1;
    sample(); chk("bp_release_rdy", 32'(in_ready), 32'd1);
    chk_out("bp_out1", 5'd1, 32'h0002_0100);
    tick(); drive(1'b1, 5'd4, 32'h0000_0400, 32'h0000_0004, 32'h0000_0001);
    sample(); chk("bp_rdy4", 32'(in_ready), 32'd1);
    chk_out("bp_out2", 5'd2, 32'h0003_0200);
    tick(); drive(1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
    sample(); chk_out("bp_out3", 5'd3, 32'h0004_0300);
    tick();
    sample(); chk_out("bp_out4", 5'd4, 32'h0005_0400);
    tick();
    sample(); chk("bp_empty", 32'(out_valid), 32'd0);

    // Flush with a stalled full pipe.
    out_ready = 1'b0;
    drive(1'b1, 5'd5, 32'h5, 32'h0, 32'h0);
    tick(); drive(1'b1, 5'd6, 32'h6, 32'h0, 32'h0);
    tick(); drive(1'b1, 5'd7, 32'h7, 32'h0, 32'h0);
    flush = 1'b1;
    sample(); chk("fl_pre_valid", 32'(out_valid), 32'd1);
    chk("fl_pre_rdy", 32'(in_ready), 32'd0);
    tick(); flush = 1'b0; drive(1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
    sample(); chk("fl_valid", 32'(out_valid), 32'd0);
    chk("fl_rdy", 32'(in_ready), 32'd1);
    tick();
    sample(); chk("fl_still_empty", 32'(out_valid), 32'd0);

    // Flush on an empty pipe drops the concurrent input.
    out_ready = 1'b1;
    drive(1'b1, 5'd10, 32'hA, 32'h0, 32'h0);
    flush = 1'b1;
    tick(); flush = 1'b0; drive(1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
    tick();
    sample(); chk("fl_drop", 32'(out_valid), 32'd0);

    // New op after flush completes normally.
    drive(1'b1, 5'd8, 32'h0000_1234, 32'h0000_0010, 32'h0000_0020);
    tick(); drive(1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
    tick();
    sample(); chk_out("post_fl", 5'd8, 32'h0030_1234);
    tick();

    // Asynchronous reset mid-stream with a full pipe.
    out_ready = 1'b0;
    drive(1'b1, 5'd11, 32'h11, 32'h0, 32'h0);
    tick(); drive(1'b1, 5'd12, 32'h12, 32'h0, 32'h0);
    tick(); drive(1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
    sample(); chk("ar_full_rdy", 32'(in_ready), 32'd0);
    #1 reset = 1'b1;
    #1;
    chk("ar_valid", 32'(out_valid), 32'd0);
    chk("ar_result", out_result, 32'h0);
    chk("ar_tag", 32'(out_tag), 32'd0);
    chk("ar_rdy", 32'(in_ready), 32'd1);
    tick();
    reset = 1'b0;
    out_ready = 1'b1;

    // Zero result flag.
    drive(1'b1, 5'd13, 32'h0, 32'h0001_0000, 32'h0);
    tick(); drive(1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
    tick();
    sample(); chk_out("zero", 5'd13, 32'h0);
    chk("zero_flag", 32'(out_zero), 32'(EXP_ZERO));
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mul_result_combiner.md
# mul_result_combiner

Pipelined accumulator stage directly downstream of the CPU multiplier cell. It takes the three registered 16x16 partial products and the cell's qualifying valid and destination tag, and assembles the low 32 bits of the 32x32 product. A two-stage pipeline with valid/ready back-pressure and a flush input delivers the result to the writeback path.

## Interface
- No parameters; all widths are fixed.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `M_mul_cell_p1`  in  32  src1[15:0] × src2[15:0].
- `M_mul_cell_p2`  in  32  src1[15:0] × src2[31:16].
- `M_mul_cell_p3`  in  32  src1[31:16] × src2[15:0].
- `mul_in_valid`  in  1  partial products and tag are valid this cycle.
- `mul_in_tag`  in  5  destination register index carried alongside the data.
- `mul_in_ready`  out  1  stage 1 can accept this cycle.
- `mul_flush`  in  1  kill all in-flight operations.
- `mul_out_ready`  in  1  consumer accepts the result.
- `mul_out_valid`  out  1  result is valid.
- `mul_out_result`  out  32  low 32 bits of the product.
- `mul_out_tag`  out  5  tag of the result.
- `mul_out_zero`  out  1  result equals zero (see Configuration).

## Operation
- **Stage 1 (S1)** registers:
  - `p1` (32 bits);
  - `cross = (p2[15:0] + p3[15:0]) mod 2^16`;
  - tag and `s1_valid`.
- **Stage 2 (S2)** registers:
  - `result = (p1 + {cross, 16'h0}) mod 2^32`;
  - tag and `s2_valid`.
- Width rule: bits [31:16] of p2 and p3 are ignored, and all carries out of bit 31 are discarded.
- Advance rules:
  - `s2_free = !s2_valid || mul_out_ready`.
  - S1 → S2 transfer when `s1_valid && s2_free`.
  - `mul_in_ready = !s1_valid || s2_free`. This is combinational and must not depend on `mul_in_valid`.
  - Input is accepted when `mul_in_valid && mul_in_ready`.
- Hold: while an output is stalled (`mul_out_valid && !mul_out_ready`), `mul_out_result`, `mul_out_tag` and `mul_out_zero` must stay stable.
- Flush:
  - When `mul_flush` = 1, the next edge clears `s1_valid` and `s2_valid`.
  - An input presented in the same cycle is dropped.
  - An output handshake in the same cycle still completes on the consumer side, but the block creates no new output from it.
- Data registers are not cleared by a flush; only the valids are.
- Reset drives all outputs to 0 except `mul_in_ready`, which is 1 (both stages empty). A reset asserted mid-operation discards everything in flight.
- The outputs `mul_out_valid`, `mul_out_result`, `mul_out_tag` and `mul_out_zero` are driven directly from S2 registers.

## Timing
- Latency: an input accepted at edge N is presented on `mul_out_valid` after edge N+1, given no stall.
- Throughput: one result per cycle while `mul_out_ready` = 1.
- Full pipe (2 entries) with `mul_out_ready` = 0: `mul_in_ready` = 0.
- Full pipe, same cycle `mul_out_ready` = 1: accept, shift and emit all occur together.
- Empty pipe: `mul_in_ready` = 1 and `mul_out_valid` = 0.
- Flush together with a stall: both stages are empty after the edge and `mul_in_ready` = 1.

## Configuration
- Macro: `MUL_COMBINE_ZERO_FLAG_EN`.
- Defined:
  - S2 additionally registers `mul_out_zero = (result == 0)`, computed from the S2-next sum.
  - The flag is held together with the result during stalls.
- Undefined:
  - `mul_out_zero` is tied to 0.
  - No extra flop or comparator is built.

## Test plan
- Basic product: p1 = 0x00000008, p2 = 0x0000000A, p3 = 0x0000000C, tag 3, `mul_out_ready` held 1 (src 0x00030002 × 0x00050004) → 2 cycles later `mul_out_result` = 0x00160008, tag 3, zero flag 0.
- Wrap-around: p1 = p2 = p3 = 0xFFFE0001 (−1 × −1) → `mul_out_result` = 0x00000001. Upper partial bits and the carry out are ignored.
- Back-pressure: 4 back-to-back inputs (tags 1–4) with `mul_out_ready` = 0 →
  - `mul_in_ready` falls after 2 accepts;
  - output tag 1 is held stable;
  - releasing ready yields tags 1, 2, 3, 4 in order with no loss or duplication.
- Flush: two ops in flight, stalled, `mul_flush` = 1 for one cycle → next cycle `mul_out_valid` = 0 and `mul_in_ready` = 1. A new op afterwards completes normally.
- Reset mid-stream: assert `reset` asynchronously (between clock edges) with a full pipe → outputs go to 0 and `mul_in_ready` = 1 immediately, without waiting for an edge.
- Zero flag with `MUL_COMBINE_ZERO_FLAG_EN`: p1 = 0, p2 = 0x00010000, p3 = 0 → result 0 and `mul_out_zero` = 1. Without the macro the flag stays 0.
